// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide sequencer beside the ALU.
// One shared adder path: shift-add multiply or restoring divide, XLEN steps.
// Optional build macro MDU_EARLY_OUT_EN: divide-by-zero, signed overflow and
// zero multiply operands skip CALC and go straight to FIX.
module mdu_seq #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CW = $clog2(XLEN);
   localparam int unsigned AW = XLEN + 2;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t          state;
   logic [2:0]      f3_q;
   logic [XLEN-1:0] opa_q;
   logic [XLEN-1:0] dvs_q;
   logic [XLEN-1:0] hi_q;
   logic [XLEN-1:0] lo_q;
   logic [CW-1:0]   cnt_q;
   logic            sgn_a_q, sgn_b_q;
   logic            div0_q, ovf_q, mzero_q;

   // Operand decode at acceptance: signedness, magnitudes, special cases
   logic            a_sgn_en, b_sgn_en, is_div;
   logic            neg_a, neg_b;
   logic [XLEN-1:0] abs_a, abs_b;
   logic            div0, ovf, mzero, early;

   always_comb begin
      a_sgn_en = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
      b_sgn_en = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
      is_div   = funct3[2];
      neg_a    = a_sgn_en & op_a[XLEN-1];
      neg_b    = b_sgn_en & op_b[XLEN-1];
      abs_a    = neg_a ? -op_a : op_a;
      abs_b    = neg_b ? -op_b : op_b;
      div0     = is_div && (op_b == '0);
      ovf      = is_div && !funct3[0] &&
                 (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
      mzero    = !is_div && ((op_a == '0) || (op_b == '0));
`ifdef MDU_EARLY_OUT_EN
      early    = div0 | ovf | mzero;
`else
      early    = 1'b0;
`endif
   end

   // Shared iteration adder: multiply accumulates, divide trial-subtracts
   logic [XLEN:0]   shifted;
   logic [AW-1:0]   add_x, add_y, sum;
   logic            add_cin;
   logic            div_ok;

   always_comb begin
      shifted = {hi_q, lo_q[XLEN-1]};
      if (f3_q[2]) begin
         add_x   = {1'b0, shifted};
         add_y   = ~{2'b00, dvs_q};
         add_cin = 1'b1;
      end else begin
         add_x   = {2'b00, hi_q};
         add_y   = lo_q[0] ? {2'b00, dvs_q} : '0;
         add_cin = 1'b0;
      end
      sum    = add_x + add_y + AW'(add_cin);
      div_ok = ~sum[AW-1];
   end

   // Sign correction, special-case forcing and output selection for FIX
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   quot, remv, sel;

   always_comb begin
      prod     = {hi_q, lo_q};
      prod_fix = (sgn_a_q ^ sgn_b_q) ? -prod : prod;
      if (mzero_q) prod_fix = '0;
      quot     = (sgn_a_q ^ sgn_b_q) ? -lo_q : lo_q;
      remv     = sgn_a_q ? -hi_q : hi_q;
      if (div0_q) begin
         quot = '1;
         remv = opa_q;
      end else if (ovf_q) begin
         quot = {1'b1, {(XLEN-1){1'b0}}};
         remv = '0;
      end
      case (f3_q)
         3'b000:                 sel = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: sel = prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         sel = quot;
         default:                sel = remv;
      endcase
   end

   // Stall covers the accepting IDLE cycle plus every in-flight cycle
   assign stall = ((state == IDLE) && start) || busy;

   // Sequencer FSM and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         f3_q    <= '0;
         opa_q   <= '0;
         dvs_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         sgn_a_q <= 1'b0;
         sgn_b_q <= 1'b0;
         div0_q  <= 1'b0;
         ovf_q   <= 1'b0;
         mzero_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  f3_q    <= funct3;
                  opa_q   <= op_a;
                  dvs_q   <= is_div ? abs_b : abs_a;
                  lo_q    <= is_div ? abs_a : abs_b;
                  hi_q    <= '0;
                  cnt_q   <= '0;
                  sgn_a_q <= neg_a;
                  sgn_b_q <= neg_b;
                  div0_q  <= div0;
                  ovf_q   <= ovf;
                  mzero_q <= mzero;
                  busy    <= 1'b1;
                  state   <= early ? FIX : CALC;
               end
            end
            CALC: begin
               if (f3_q[2]) begin
                  hi_q <= div_ok ? sum[XLEN-1:0] : shifted[XLEN-1:0];
                  lo_q <= {lo_q[XLEN-2:0], div_ok};
               end else begin
                  hi_q <= sum[XLEN:1];
                  lo_q <= {sum[0], lo_q[XLEN-1:1]};
               end
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(XLEN-1)) state <= FIX;
            end
            FIX: begin
               result <= sel;
               busy   <= 1'b0;
               done   <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed RV32M vectors with hand-computed results and latency.
module tb_mdu_seq;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned FULL_LAT = XLEN + 2;
`ifdef MDU_EARLY_OUT_EN
   localparam int unsigned SPEC_LAT = 2;
`else
   localparam int unsigned SPEC_LAT = XLEN + 2;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a, op_b;
   logic            stall, busy, done;
   logic [XLEN-1:0] result;

   int n_assert = 0;
   int n_fail   = 0;

   mdu_seq #(.XLEN(XLEN)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .stall  (stall),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Sample at falling edges until done; count pre-done cycles and stall cycles
   task automatic wait_done(input string tag, output int n, output int ns);
      bit seen;
      seen = 0;
      n    = 0;
      ns   = 0;
      while (!seen && n < 200) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1;
         else begin
            n++;
            if (stall === 1'b1) ns++;
         end
      end
      chk({tag, " done seen"}, 32'(seen), 32'd1);
      if (seen) chk({tag, " stall in done"}, 32'(stall), 32'd0);
   endtask

   task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expv, input int lat);
      int n, ns;
      @(posedge clk); #1;
      funct3 = f; op_a = a; op_b = b; start = 1'b1;
      wait_done(tag, n, ns);
      start = 1'b0;
      chk({tag, " result"}, result, expv);
      chk({tag, " latency"}, 32'(n), 32'(lat));
      chk({tag, " stall cycles"}, 32'(ns), 32'(lat));
   endtask

   initial begin
      int n, ns;
      reset = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset result", result, 32'd0);
      chk("reset stall", 32'(stall), 32'd0);
      @(posedge clk); #1 reset = 1'b0;

      do_op("MUL 7x-3",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, FULL_LAT);
      do_op("MULH min^2",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, FULL_LAT);
      do_op("MULHU max^2",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, FULL_LAT);
      do_op("MULHSU -1xmx", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, FULL_LAT);
      do_op("DIV -7/2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, FULL_LAT);
      do_op("REM -7/2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, FULL_LAT);
      do_op("DIVU 100/7",   3'b101, 32'd100,      32'd7,        32'd14,       FULL_LAT);
      do_op("REMU 100/7",   3'b111, 32'd100,      32'd7,        32'd2,        FULL_LAT);
      do_op("DIVU 13/0",    3'b101, 32'd13,       32'd0,        32'hFFFFFFFF, SPEC_LAT);
      do_op("REMU 13/0",    3'b111, 32'd13,       32'd0,        32'd13,       SPEC_LAT);
      do_op("DIV ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPEC_LAT);
      do_op("REM ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        SPEC_LAT);

      // start held through DONE, operands changed mid-CALC, then back-to-back op
      @(posedge clk); #1;
      funct3 = 3'b000; op_a = 32'd6; op_b = 32'd7; start = 1'b1;
      repeat (10) @(posedge clk);
      #1 op_a = 32'd100; op_b = 32'd1;
      wait_done("hold MUL", n, ns);
      chk("hold MUL result", result, 32'd42);
      funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
      @(negedge clk);
      chk("hold single pulse", 32'(done), 32'd0);
      chk("b2b accept stall", 32'(stall), 32'd1);
      chk("b2b idle busy", 32'(busy), 32'd0);
      wait_done("b2b DIVU", n, ns);
      start = 1'b0;
      chk("b2b DIVU result", result, 32'd14);
      chk("b2b DIVU latency", 32'(n), 32'(FULL_LAT - 1));

      // reset in the middle of CALC abandons the op
      @(posedge clk); #1;
      funct3 = 3'b000; op_a = 32'd6; op_b = 32'd7; start = 1'b1;
      @(posedge clk);
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("mid busy before reset", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid reset busy", 32'(busy), 32'd0);
      chk("mid reset done", 32'(done), 32'd0);
      chk("mid reset result", result, 32'd0);
      chk("mid reset stall start=1", 32'(stall), 32'd1);
      start = 1'b0;
      #1 chk("mid reset stall start=0", 32'(stall), 32'd0);
      @(posedge clk); #1 reset = 1'b0;

      do_op("MUL 3x5", 3'b000, 32'd3, 32'd5, 32'd15, FULL_LAT);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer that adds RV32M to the single-cycle core. It sits beside the ALU: funct7=0000001 with opcode OP routes to this block instead of the ALU.
- It drives a stall to the PC/regfile write-enable until the result is ready.
- It uses one shared adder/shifter iteration path for all eight M ops, sequenced by a small FSM.

Parameters:
- XLEN, 32, operand/result width; iteration count = XLEN.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  M-instruction present in the current cycle (level, held by core while stalled).
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 value.
- op_b  input  XLEN  rs2 value.
- stall  output  1  freeze PC and regfile write this cycle.
- busy  output  1  operation in flight (CALC or FIX).
- done  output  1  one-cycle pulse; result valid; core commits this cycle.
- result  output  XLEN  rd value; held stable from done until next accepted start.

Behaviour:
- Reset (synchronous, any state):
  - state=IDLE; busy=0, done=0, result=0.
  - All internal accumulators, counter and latched operands cleared; an in-flight op is abandoned with no residue.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 → latch funct3, op_a, op_b; take absolute values per signedness (MULH/DIV/REM: both signed; MULHSU: op_a signed only; MUL, MULHU, DIVU, REMU: unsigned); record result sign; counter=0; go CALC.
  - start=0 → stay.
- CALC: one iteration per cycle; counter increments; exits to FIX after exactly XLEN cycles (counter wrap from XLEN-1).
  - Multiply: shift-add into a 2*XLEN product.
  - Divide: restoring division, one quotient bit per cycle, XLEN-bit remainder with one guard bit.
- FIX:
  - Apply sign correction (two's-complement negate when the recorded sign is set). Quotient sign = sign_a XOR sign_b; remainder sign = sign_a.
  - Select the output: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder.
  - Register the selection into result; go DONE.
- DONE: done=1 for this one cycle, then IDLE. start is ignored in DONE, because it still reflects the committing instruction.
- start while busy: ignored; latched operands must not change.
- stall = (IDLE & start) | CALC | FIX. stall=0 in DONE.
- busy = CALC | FIX.
- Latency: start sampled at edge T → done high in the cycle after edge T+XLEN+1, i.e. XLEN+2 cycles of stall (34 for XLEN=32).
- Divide by zero: quotient = all ones (DIVU 0xFFFFFFFF, DIV -1); remainder = op_a. No trap.
- Signed overflow (DIV/REM with op_a=0x80000000, op_b=-1): quotient=0x80000000, remainder=0.
- Both special cases are detected at start and forced in FIX, regardless of the CALC datapath.
- Arithmetic is all modulo 2^XLEN on output; no overflow flags.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: divide-by-zero, signed overflow, or either multiply operand = 0 skips CALC (IDLE→FIX→DONE). Latency is 2 cycles and stall lasts 2 cycles. The forced result values are unchanged.
- Undefined: every op takes the full XLEN+2 cycles; timing is data-independent.

Test Plan:
- MUL 7 × 0xFFFFFFFD (-3) → result 0xFFFFFFEB, done exactly 34 cycles after start is sampled, stall high for 34 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Specials, each checked with and without MDU_EARLY_OUT_EN (34 vs 2 cycles):
  - DIVU 13/0 → 0xFFFFFFFF; REMU 13/0 → 13.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Hold start=1 through DONE with changing op_a mid-CALC → single done pulse, result uses operands latched at start, no restart; back-to-back M op accepted in the next IDLE cycle.
- Assert reset at CALC cycle 10 → next cycle busy=0, done=0, result=0, stall follows start only. A following MUL 3×5 → 15 with full latency.
